// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter.
// Latency: none. This file holds only types, constants and one helper.
// Backpressure: not applicable.
//
// Contents:
//   state_t        - controller states (IDLE, SHIFT, DONE)
//   BCD_NIBBLE_W   - bits per packed decimal digit
//   BCD_MAX_DIGIT  - largest legal decimal digit value
//   ADJ_THRESHOLD  - nibble value at or above which a correction is applied
//   ADJ_SUBTRACT   - correction amount applied after each right shift
//   nibble_invalid - true for a nibble that is not a decimal digit
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BCD_NIBBLE_W = 4;

  localparam logic [BCD_NIBBLE_W-1:0] BCD_MAX_DIGIT = 4'd9;

  // A right shift moves the low bit of the next digit into bit 3 of this one.
  // That bit is worth 10/2 = 5 here, but it reads as 8. Subtracting 3 fixes it.
  localparam logic [BCD_NIBBLE_W-1:0] ADJ_THRESHOLD = 4'd8;
  localparam logic [BCD_NIBBLE_W-1:0] ADJ_SUBTRACT  = 4'd3;

  function automatic logic nibble_invalid(input logic [BCD_NIBBLE_W-1:0] nib);
    return nib > BCD_MAX_DIGIT;
  endfunction

endpackage

// File: rtl/bcd_nibble_adjust.sv
// Per-digit correction that follows each right shift in reverse double-dabble.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input.
//
// Ports:
//   nibble_in  - one BCD digit, already shifted right by one
//   nibble_out - nibble_in - 3 when nibble_in >= 8, otherwise nibble_in
//                (4-bit unsigned arithmetic, no borrow to other digits)
module bcd_nibble_adjust
  import bcd_pkg::*;
(
  input  logic [BCD_NIBBLE_W-1:0] nibble_in,
  output logic [BCD_NIBBLE_W-1:0] nibble_out
);

  always_comb begin
    nibble_out = nibble_in;
    if (nibble_in >= ADJ_THRESHOLD) begin
      nibble_out = nibble_in - ADJ_SUBTRACT;
    end
  end

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential packed-BCD to binary converter (reverse double-dabble, one shift per clock).
// Latency: a valid start taken at edge N shows done in the cycle after edge N+BIN_W.
//          A bad digit shows done in the cycle right after the accepting edge.
// Backpressure: start is sampled only in IDLE. A start in SHIFT or DONE is dropped, not queued.
//
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   start      - conversion request (sampled in IDLE only)
//   bcd_in     - DIGITS packed BCD digits, most significant digit in the top nibble
//   busy       - high while iterating (SHIFT state)
//   done       - one-cycle pulse, result valid
//   binary     - converted value, held until the next accepted start
//   overflow   - decimal value >= 2**BIN_W, held with binary
//   bad_digit  - some input nibble > 9, held with binary (binary forced to 0)
//
// Build option BCD2BIN_SATURATE_EN: when defined, an overflowing result reads all ones.
// When undefined, an overflowing result keeps the value modulo 2**BIN_W.
module bcd_to_binary_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [BCD_NIBBLE_W*DIGITS-1:0] bcd_in,
  output logic                       busy,
  output logic                       done,
  output logic [BIN_W-1:0]           binary,
  output logic                       overflow,
  output logic                       bad_digit
);

  localparam int BCD_W = BCD_NIBBLE_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] iter_cnt;
  logic [BCD_W-1:0] bcd_reg;
  logic [BCD_W-1:0] bcd_shift;
  logic [BCD_W-1:0] bcd_adj;
  logic [BIN_W-1:0] bin_reg;
  logic [BIN_W-1:0] bin_shift;
  logic             in_bad;
  logic             last_iter;
  logic             result_ovf;
  logic [BIN_W-1:0] result_bin;

  // Any non-decimal nibble on the input aborts the conversion at capture.
  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (nibble_invalid(bcd_in[i*BCD_NIBBLE_W +: BCD_NIBBLE_W])) begin
        in_bad = 1'b1;
      end
    end
  end

  // One iteration: {bcd_reg, bin_reg} >> 1, then correct each BCD digit.
  assign bcd_shift = {1'b0, bcd_reg[BCD_W-1:1]};
  assign bin_shift = {bcd_reg[0], bin_reg[BIN_W-1:1]};

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_nibble_adjust u_adj (
      .nibble_in  (bcd_shift[g*BCD_NIBBLE_W +: BCD_NIBBLE_W]),
      .nibble_out (bcd_adj[g*BCD_NIBBLE_W +: BCD_NIBBLE_W])
    );
  end

  // Flag the iteration that completes BIN_W shifts.
  assign last_iter = (iter_cnt + CNT_W'(1)) == LAST_ITER;

  // After BIN_W halvings the BCD side holds floor(value / 2**BIN_W).
  // If anything is left there, the value did not fit.
  assign result_ovf = (bcd_adj != '0);

`ifdef BCD2BIN_SATURATE_EN
  assign result_bin = result_ovf ? '1 : bin_shift;
`else
  assign result_bin = bin_shift;
`endif

  // Controller: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Controller: next state.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = in_bad ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (last_iter) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  // Datapath and held results. The results change only at capture (cleared)
  // and on entry to DONE, so they stay stable between conversions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_reg   <= '0;
      bin_reg   <= '0;
      iter_cnt  <= '0;
      binary    <= '0;
      overflow  <= 1'b0;
      bad_digit <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bcd_reg   <= bcd_in;
            bin_reg   <= '0;
            iter_cnt  <= '0;
            binary    <= '0;
            overflow  <= 1'b0;
            bad_digit <= in_bad;
          end
        end
        SHIFT: begin
          bcd_reg  <= bcd_adj;
          bin_reg  <= bin_shift;
          iter_cnt <= iter_cnt + CNT_W'(1);
          if (last_iter) begin
            binary   <= result_bin;
            overflow <= result_ovf;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq: a 10-bit and an 8-bit instance,
// checked every cycle against a behavioural timeline model, plus directed checks.
module tb_bcd_to_binary_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start8;
  logic [11:0] bcd_in, bcd8;
  logic        busy, done, overflow, bad_digit;
  logic [9:0]  binary;
  logic        busy8, done8, overflow8, bad8;
  logic [7:0]  binary8;

  int checks = 0;
  int fails  = 0;
  int done_pulses = 0;

`ifdef BCD2BIN_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  always #5 clk = ~clk;

  bcd_to_binary_seq #(.DIGITS(3), .BIN_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bcd_in(bcd_in),
    .busy(busy), .done(done), .binary(binary), .overflow(overflow), .bad_digit(bad_digit)
  );

  bcd_to_binary_seq #(.DIGITS(3), .BIN_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .bcd_in(bcd8),
    .busy(busy8), .done(done8), .binary(binary8), .overflow(overflow8), .bad_digit(bad8)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference conversion from decimal arithmetic.
  function automatic void ref_conv(input logic [11:0] b, input int w,
                                   output int bin, output bit ovf, output bit bad);
    int val = 0;
    bad = 1'b0;
    for (int d = 2; d >= 0; d--) begin
      int dig = int'(b[d*4 +: 4]);
      if (dig > 9) bad = 1'b1;
      val = val * 10 + dig;
    end
    ovf = 1'b0;
    bin = 0;
    if (!bad) begin
      ovf = (val >= (1 << w));
      bin = !ovf ? val : (SAT ? (1 << w) - 1 : val % (1 << w));
    end
  endfunction

  // Timeline model: rem = edges left until done shows; done_e = done visible now.
  typedef struct {
    int rem;
    bit done_e;
    int bin_e;
    bit ovf_e;
    bit bad_e;
    int pend_bin;
    bit pend_ovf;
  } mdl_t;

  mdl_t m0, m8;

  function automatic mdl_t step(input mdl_t s, input bit st, input logic [11:0] b, input int w);
    mdl_t n = s;
    int pb;
    bit po, pbad;
    n.done_e = 1'b0;
    if (s.done_e) begin
      // done cycle: back to idle, any start now is dropped
    end else if (s.rem > 0) begin
      n.rem = s.rem - 1;
      if (n.rem == 0) begin
        n.done_e = 1'b1;
        n.bin_e  = s.pend_bin;
        n.ovf_e  = s.pend_ovf;
      end
    end else if (st) begin
      ref_conv(b, w, pb, po, pbad);
      n.bin_e = 0;
      n.ovf_e = 1'b0;
      n.bad_e = pbad;
      if (pbad) begin
        n.done_e = 1'b1;
      end else begin
        n.rem      = w;
        n.pend_bin = pb;
        n.pend_ovf = po;
      end
    end
    return n;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m0 = '{default: 0};
      m8 = '{default: 0};
    end else begin
      m0 = step(m0, start, bcd_in, 10);
      m8 = step(m8, start8, bcd8, 8);
    end
  end

  // Per-cycle comparison of both instances against the model.
  initial forever begin
    @(negedge clk);
    chk("busy",      busy,      m0.rem > 0);
    chk("done",      done,      m0.done_e);
    chk("binary",    binary,    m0.bin_e);
    chk("overflow",  overflow,  m0.ovf_e);
    chk("bad_digit", bad_digit, m0.bad_e);
    chk("busy8",     busy8,     m8.rem > 0);
    chk("done8",     done8,     m8.done_e);
    chk("binary8",   binary8,   m8.bin_e);
    chk("overflow8", overflow8, m8.ovf_e);
    chk("bad8",      bad8,      m8.bad_e);
    if (done === 1'b1) done_pulses++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 after the accept edge.
  task automatic go(input logic [11:0] v);
    bcd_in = v;
    start  = 1'b1;
    tick(1);
    start  = 1'b0;
  endtask

  // Edges from the accepting edge until done is visible, and busy cycles before that.
  task automatic wait_done(output int edges, output int busy_cycles);
    edges = 0;
    busy_cycles = 0;
    while (done !== 1'b1 && edges < 40) begin
      if (busy === 1'b1) busy_cycles++;
      tick(1);
      edges++;
    end
    if (done !== 1'b1) chk("done_timeout", done, 1);
  endtask

  function automatic logic [11:0] rand_bcd();
    logic [11:0] v;
    for (int d = 0; d < 3; d++) begin
      v[d*4 +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                 : 4'($urandom_range(0, 9));
    end
    return v;
  endfunction

  initial begin
    int b, n, nb, dp;
    bit o, bd;
    logic [11:0] lit;

    rst_n = 1'b0; start = 1'b0; start8 = 1'b0; bcd_in = '0; bcd8 = '0;

    // Pin the reference model with hand-computed values.
    lit = 12'h300; ref_conv(lit, 10, b, o, bd);
    chk("pin_300_bin", b, 300); chk("pin_300_ovf", o, 0); chk("pin_300_bad", bd, 0);
    lit = 12'h999; ref_conv(lit, 10, b, o, bd);
    chk("pin_999_bin", b, 999);
    lit = 12'h1A5; ref_conv(lit, 10, b, o, bd);
    chk("pin_1a5_bad", bd, 1); chk("pin_1a5_bin", b, 0);
    lit = 12'h300; ref_conv(lit, 8, b, o, bd);
    chk("pin_300w8_ovf", o, 1); chk("pin_300w8_bin", b, SAT ? 255 : 44);

    // Reset state.
    tick(2);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_binary", binary, 0);
    chk("rst_ovf", overflow, 0); chk("rst_bad", bad_digit, 0);
    #3 rst_n = 1'b1;
    tick(2);

    // 300: done visible in cycle N+BIN_W+1, i.e. BIN_W edges after accepting edge N.
    go(12'h300);
    wait_done(n, nb);
    chk("t1_latency", n, 10); chk("t1_busy_cycles", nb, 10);
    chk("t1_binary", binary, 300); chk("t1_ovf", overflow, 0); chk("t1_bad", bad_digit, 0);
    tick(1);

    go(12'h999);
    wait_done(n, nb);
    chk("t2_binary", binary, 999); chk("t2_busy_cycles", nb, 10);
    tick(1);
    go(12'h000);
    wait_done(n, nb);
    chk("t2b_binary", binary, 0); chk("t2b_busy_cycles", nb, 10);
    tick(1);

    // Bad digit: done right after the accepting edge, busy never seen.
    go(12'h1A5);
    wait_done(n, nb);
    chk("t3_latency", n, 0); chk("t3_busy_cycles", nb, 0); chk("t3_busy", busy, 0);
    chk("t3_bad", bad_digit, 1); chk("t3_binary", binary, 0);
    tick(1);

    // 8-bit instance overflow.
    bcd8 = 12'h300; start8 = 1'b1; tick(1); start8 = 1'b0;
    n = 0;
    while (done8 !== 1'b1 && n < 40) begin tick(1); n++; end
    chk("t4_done8", done8, 1); chk("t4_ovf8", overflow8, 1);
    chk("t4_binary8", binary8, SAT ? 255 : 44);
    tick(1);

    // Start during SHIFT is dropped.
    dp = done_pulses;
    go(12'h123);
    tick(3);
    bcd_in = 12'h456; start = 1'b1; tick(1); start = 1'b0;
    wait_done(n, nb);
    chk("t5_binary", binary, 123);
    tick(15);
    chk("t5_done_pulses", done_pulses - dp, 1);

    // Asynchronous reset mid-SHIFT.
    dp = done_pulses;
    go(12'h777);
    tick(3);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_busy", busy, 0); chk("t6_done", done, 0); chk("t6_binary", binary, 0);
    chk("t6_ovf", overflow, 0); chk("t6_bad", bad_digit, 0);
    tick(2);
    #3 rst_n = 1'b1;
    tick(1);
    chk("t6_no_done", done_pulses - dp, 0);
    go(12'h042);
    wait_done(n, nb);
    chk("t6_latency", n, 10); chk("t6_binary42", binary, 42);
    tick(1);

    // Randomized traffic, with alternating stretches of held start.
    for (int i = 0; i < 800; i++) begin
      bcd_in = rand_bcd();
      bcd8   = rand_bcd();
      start  = ((i / 100) % 2 == 1) ? 1'b1 : ($urandom_range(0, 2) == 0);
      start8 = ((i / 100) % 2 == 1) ? 1'b1 : ($urandom_range(0, 2) == 0);
      tick(1);
    end
    start = 1'b0; start8 = 1'b0;
    tick(15);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
